ws2812_frame_ctrl: RTL

//  Sequences the 120-bit GRB shift register (5 LEDs x 24 bits) onto the WS2812 data line.
//  On start it loads the register, then emits one timed high/low bit window per MSB.
//  It rotates the register once per bit and finishes each frame with a latch (reset) gap.

---
 rtl/ws2812_frame_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/ws2812_frame_ctrl.sv
// WS2812 frame sequencer: LOAD, NUM_BITS timed bit windows, then a latch gap.
// Define WS_AUTO_REFRESH_EN to re-load and resend continuously after every latch gap.
module ws2812_frame_ctrl #(
   parameter int NUM_BITS = 120,
   parameter int T_BIT    = 62,
   parameter int T0H      = 20,
   parameter int T1H      = 40,
   parameter int T_LATCH  = 2500
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic current_bit,
   output logic load_reg,
   output logic rotate_reg,
   output logic led_dout,
   output logic busy,
   output logic frame_done
);

   localparam int CW = $clog2(T_BIT + 1);
   localparam int BW = $clog2(NUM_BITS + 1);
   localparam int LW = $clog2(T_LATCH + 1);

   localparam logic [CW-1:0] CYC_LAST = CW'(T_BIT - 1);
   localparam logic [CW-1:0] HI0      = CW'(T0H);
   localparam logic [CW-1:0] HI1      = CW'(T1H);
   localparam logic [BW-1:0] BIT_LAST = BW'(NUM_BITS - 1);
   localparam logic [LW-1:0] LAT_LAST = LW'(T_LATCH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_SEND,
      S_LATCH
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cyc_q, cyc_d;
   logic [BW-1:0] bitc_q, bitc_d;
   logic [LW-1:0] lat_q, lat_d;
   logic          bit_q, bit_d;
   logic          led_q, led_d;
   logic          cur;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cyc_q   <= '0;
         bitc_q  <= '0;
         lat_q   <= '0;
         bit_q   <= 1'b0;
         led_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         bitc_q  <= bitc_d;
         lat_q   <= lat_d;
         bit_q   <= bit_d;
         led_q   <= led_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cyc_d      = cyc_q;
      bitc_d     = bitc_q;
      lat_d      = lat_q;
      bit_d      = bit_q;
      led_d      = 1'b0;
      load_reg   = 1'b0;
      rotate_reg = 1'b0;
      frame_done = 1'b0;
      busy       = (state_q != S_IDLE);
      cur        = bit_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) state_d = S_LOAD;
         end
         S_LOAD: begin
            load_reg = 1'b1;
            bitc_d   = '0;
            cyc_d    = '0;
            state_d  = S_SEND;
         end
         S_SEND: begin
            // First window cycle uses the live MSB; bit_q holds it afterwards
            if (cyc_q == '0) begin
               cur   = current_bit;
               bit_d = current_bit;
            end
            led_d = (cyc_q < (cur ? HI1 : HI0));
            if (cyc_q == CYC_LAST) begin
               rotate_reg = 1'b1;
               cyc_d      = '0;
               if (bitc_q == BIT_LAST) begin
                  lat_d   = '0;
                  state_d = S_LATCH;
               end else begin
                  bitc_d = bitc_q + 1'b1;
               end
            end else begin
               cyc_d = cyc_q + 1'b1;
            end
         end
         S_LATCH: begin
            if (lat_q == LAT_LAST) begin
               frame_done = 1'b1;
               lat_d      = '0;
`ifdef WS_AUTO_REFRESH_EN
               state_d    = S_LOAD;
`else
               state_d    = S_IDLE;
`endif
            end else begin
               lat_d = lat_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign led_dout = led_q;

endmodule
